// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline scheduler: MA control bit positions,
// PC source encodings and the data-memory wait FSM state type.
package pipe_ctrl_pkg;

    // Bit positions inside the MA_M control field carried by the EX/MA register
    localparam int MA_RD = 0;
    localparam int MA_WR = 1;
    localparam int MA_BR = 2;
    localparam int MA_J  = 3;

    // PC source select encodings
    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_J   = 2'd2;

    // Data-memory handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    // True when the instruction in MA touches data memory
    function automatic logic is_mem_access(input logic [3:0] ctrl);
        return ctrl[MA_RD] | ctrl[MA_WR];
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Sequences variable-latency data-memory accesses in MA through the
// request/ready handshake and trips a sticky error when the memory never
// answers within TIMEOUT wait cycles.
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ma_access_i,
    input  logic mem_ready_i,
    output logic mem_req_o,
    output logic mem_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t       state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             mem_err_q;

    // State, wait counter and sticky error flag; the counter holds the number
    // of the current WAIT cycle and is zero whenever the FSM is not waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ma_access_i && !mem_ready_i) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= CNT_ONE;
                    end
                end
                WAIT: begin
                    if (mem_ready_i) begin
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_q    <= ERR;
                        wait_cnt_q <= '0;
                        mem_err_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_ONE;
                    end
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q    <= IDLE;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    // Request follows the MA access in IDLE so zero-wait accesses cost nothing,
    // is held through WAIT, and is withdrawn for good once the access failed
    always_comb begin
        mem_req_o = 1'b0;
        case (state_q)
            IDLE:    mem_req_o = ma_access_i;
            WAIT:    mem_req_o = 1'b1;
            default: mem_req_o = 1'b0;
        endcase
    end

    assign mem_err_o = mem_err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline scheduler for the five-stage MIPS core: produces the hold and
// bubble enables for the pipeline registers and the PC source select,
// resolving load-use hazards, MA-resolved redirects and memory wait states.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              ex_load,
    input  logic [4:0]        ex_rt,
    input  logic [3:0]        ma_ctrl,
    input  logic              zf_m,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [1:0]        pc_src,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [PERF_W-1:0] CNT_ONE = PERF_W'(1);

    logic              ma_access;
    logic              mem_stall;
    logic              load_use;
    logic              redirect;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    assign ma_access = is_mem_access(ma_ctrl);

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_fsm (
        .clk         (clk),
        .rst         (rst),
        .ma_access_i (ma_access),
        .mem_ready_i (mem_ready),
        .mem_req_o   (mem_req),
        .mem_err_o   (mem_err)
    );

    // Hazard detection: a register-zero destination never creates a dependency
    always_comb begin
        mem_stall = mem_req & ~mem_ready;
        load_use  = ex_load && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

    // Redirect select: a jump wins over a taken branch
    always_comb begin
        pc_src = PC_SEQ;
        if (ma_ctrl[MA_J]) begin
            pc_src = PC_J;
        end else if (ma_ctrl[MA_BR] && zf_m) begin
            pc_src = PC_BR;
        end
        redirect = (pc_src != PC_SEQ);
    end

    // Stall/flush priority: a memory stall freezes everything, a redirect
    // squashes the three younger instructions, otherwise a load-use bubble
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Memory-stall performance counter sticks at all-ones instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Performance counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
